// File: rtl/proc_defs.sv
// Shared definitions for the multicycle processor control path:
// opcodes, step numbers, control FSM encoding and the PC register index.
package proc_defs;

  localparam logic [2:0] OP_MV   = 3'd0;
  localparam logic [2:0] OP_MVI  = 3'd1;
  localparam logic [2:0] OP_ADD  = 3'd2;
  localparam logic [2:0] OP_SUB  = 3'd3;
  localparam logic [2:0] OP_LD   = 3'd4;
  localparam logic [2:0] OP_ST   = 3'd5;
  localparam logic [2:0] OP_MVNZ = 3'd6;
  localparam logic [2:0] OP_RSV  = 3'd7;

  localparam logic [2:0] T0 = 3'd0;
  localparam logic [2:0] T1 = 3'd1;
  localparam logic [2:0] T2 = 3'd2;
  localparam logic [2:0] T3 = 3'd3;
  localparam logic [2:0] T4 = 3'd4;
  localparam logic [2:0] T5 = 3'd5;
  localparam logic [2:0] T6 = 3'd6;
  localparam logic [2:0] T7 = 3'd7;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EXEC = 1'b1
  } state_t;

  localparam logic [2:0] PC_IDX = 3'd7;

endpackage

// File: rtl/unidade_controle_if.sv
// Datapath-facing bundle of the control unit: memory data and G flag in,
// register-file selects and datapath strobes out.
interface unidade_controle_if #(parameter int N = 9);

  logic [N-1:0] DIN;
  logic         G_zero;
  logic [7:0]   Rout;
  logic [7:0]   Rin;
  logic         Gout;
  logic         DINout;
  logic         Ain;
  logic         Gin;
  logic         AddSub;
  logic         ADDRin;
  logic         DOUTin;
  logic         W_D;
  logic         incr_pc;
  logic         IRin;

  modport master (
    input  DIN, G_zero,
    output Rout, Rin, Gout, DINout, Ain, Gin, AddSub,
           ADDRin, DOUTin, W_D, incr_pc, IRin
  );

  modport slave (
    output DIN, G_zero,
    input  Rout, Rin, Gout, DINout, Ain, Gin, AddSub,
           ADDRin, DOUTin, W_D, incr_pc, IRin
  );

endinterface

// File: rtl/dec3to8.sv
// 3-bit index to one-hot 8 decoder with enable; all-zero when disabled.
module dec3to8 (
  input  logic [2:0] idx,
  input  logic       en,
  output logic [7:0] onehot
);

  assign onehot = en ? (8'd1 << idx) : 8'd0;

endmodule

// File: rtl/unidade_controle.sv
// Instruction-sequencing control unit: IR register plus opcode x step decode.
// Build option CTRL_MVNZ_EN enables opcode 110 as mvnz; otherwise it is reserved.
//
// state   | meaning
// --------+---------------------------------------------------------------
// ST_IDLE | waiting for Run; step counter held clear, no strobes
// ST_EXEC | fetching/executing; step from Tstep, IR holds current opcode
module unidade_controle
  import proc_defs::*;
#(
  parameter int N = 9
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       Run,
  input  logic [2:0] Tstep,
  output logic       Clear,
  output logic       Done,
  output logic       Illegal,
  unidade_controle_if.master dp
);

  state_t       state, state_nxt;
  logic [N-1:0] ir;
  logic [2:0]   op, rx, ry;

  logic         rout_en, rin_en;
  logic [2:0]   rout_idx, rin_idx;
  logic [7:0]   rout, rin;
  logic         gout, dinout, ain, gin, addsub, addrin, doutin, w_d, incr_pc, ir_in;
  logic         done, illegal;

  assign op = ir[8:6];
  assign rx = ir[5:3];
  assign ry = ir[2:0];

  always_ff @(posedge Clock) begin
    if (Reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // ir_in is only ever raised at T2 of EXEC, so IR cannot move at any other time
  always_ff @(posedge Clock) begin
    if (Reset)      ir <= '0;
    else if (ir_in) ir <= dp.DIN;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: if (Run) state_nxt = ST_EXEC;
      ST_EXEC: if (done && !Run) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    rout_en  = 1'b0;
    rout_idx = 3'd0;
    rin_en   = 1'b0;
    rin_idx  = 3'd0;
    gout     = 1'b0;
    dinout   = 1'b0;
    ain      = 1'b0;
    gin      = 1'b0;
    addsub   = 1'b0;
    addrin   = 1'b0;
    doutin   = 1'b0;
    w_d      = 1'b0;
    incr_pc  = 1'b0;
    ir_in    = 1'b0;
    done     = 1'b0;
    illegal  = 1'b0;
    if (state == ST_EXEC) begin
      unique case (Tstep)
        T0: begin
          rout_en = 1'b1; rout_idx = PC_IDX; addrin = 1'b1; incr_pc = 1'b1;
        end
        T1: ;
        T2: begin
          dinout = 1'b1; ir_in = 1'b1;
        end
        default: begin
          // T6/T7 match no arm below: they drive nothing
          unique case (op)
            OP_MV: if (Tstep == T3) begin
              rout_en = 1'b1; rout_idx = ry; rin_en = 1'b1; rin_idx = rx; done = 1'b1;
            end
            OP_MVI: begin
              if (Tstep == T3) begin
                rout_en = 1'b1; rout_idx = PC_IDX; addrin = 1'b1; incr_pc = 1'b1;
              end else if (Tstep == T5) begin
                dinout = 1'b1; rin_en = 1'b1; rin_idx = rx; done = 1'b1;
              end
            end
            OP_ADD, OP_SUB: begin
              if (Tstep == T3) begin
                rout_en = 1'b1; rout_idx = rx; ain = 1'b1;
              end else if (Tstep == T4) begin
                rout_en = 1'b1; rout_idx = ry; gin = 1'b1; addsub = op[0];
              end else if (Tstep == T5) begin
                gout = 1'b1; rin_en = 1'b1; rin_idx = rx; done = 1'b1;
              end
            end
            OP_LD: begin
              if (Tstep == T3) begin
                rout_en = 1'b1; rout_idx = ry; addrin = 1'b1;
              end else if (Tstep == T5) begin
                dinout = 1'b1; rin_en = 1'b1; rin_idx = rx; done = 1'b1;
              end
            end
            OP_ST: begin
              if (Tstep == T3) begin
                rout_en = 1'b1; rout_idx = ry; addrin = 1'b1;
              end else if (Tstep == T4) begin
                rout_en = 1'b1; rout_idx = rx; doutin = 1'b1; w_d = 1'b1; done = 1'b1;
              end
            end
`ifdef CTRL_MVNZ_EN
            OP_MVNZ: if (Tstep == T3) begin
              done = 1'b1;
              if (!dp.G_zero) begin
                rout_en = 1'b1; rout_idx = ry; rin_en = 1'b1; rin_idx = rx;
              end
            end
`else
            OP_MVNZ: if (Tstep == T3) begin
              done = 1'b1; illegal = 1'b1;
            end
`endif
            default: if (Tstep == T3) begin
              done = 1'b1; illegal = 1'b1;
            end
          endcase
        end
      endcase
    end
  end

`ifndef CTRL_MVNZ_EN
  logic g_zero_unused;
  assign g_zero_unused = dp.G_zero;
`endif

  dec3to8 u_rout_dec (.idx(rout_idx), .en(rout_en), .onehot(rout));
  dec3to8 u_rin_dec  (.idx(rin_idx),  .en(rin_en),  .onehot(rin));

  assign Done    = done;
  assign Illegal = illegal;
  assign Clear   = done || (state == ST_IDLE) || (Tstep == T7);

  assign dp.Rout    = rout;
  assign dp.Rin     = rin;
  assign dp.Gout    = gout;
  assign dp.DINout  = dinout;
  assign dp.Ain     = ain;
  assign dp.Gin     = gin;
  assign dp.AddSub  = addsub;
  assign dp.ADDRin  = addrin;
  assign dp.DOUTin  = doutin;
  assign dp.W_D     = w_d;
  assign dp.incr_pc = incr_pc;
  assign dp.IRin    = ir_in;

endmodule

// File: tb/tb_unidade_controle.sv
// Bench for unidade_controle: bus-transfer model of each instruction step,
// step counter modelled in the bench, directed instruction sequence.
module tb_unidade_controle;

  typedef struct packed {
    logic       clear, done, illegal;
    logic [7:0] rout, rin;
    logic       gout, dinout, ain, gin, addsub, addrin, doutin, w_d, incr_pc, irin;
  } out_t;

`ifdef CTRL_MVNZ_EN
  localparam bit MVNZ_EN = 1'b1;
`else
  localparam bit MVNZ_EN = 1'b0;
`endif

  logic       Clock = 1'b0;
  logic       Reset = 1'b1;
  logic       Run = 1'b0;
  logic [2:0] Tstep = 3'd0;
  logic       Clear, Done, Illegal;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  bit         m_exec = 1'b0;
  int         m_step = 0;
  logic [8:0] m_ir = '0;
  out_t       e_now, act;

  unidade_controle_if #(.N(9)) dp_if ();

  unidade_controle #(.N(9)) dut (
    .Clock(Clock), .Reset(Reset), .Run(Run), .Tstep(Tstep),
    .Clear(Clear), .Done(Done), .Illegal(Illegal), .dp(dp_if)
  );

  always #5 Clock = ~Clock;

  // Each step is one bus transfer: a source (register, G or DIN) and a destination.
  function automatic out_t model_out(bit exec, int step, logic [8:0] ir, logic gz);
    out_t e;
    int op, rx, ry, k, src, dst;
    e = '0; src = -1; dst = -1;
    op = int'(ir[8:6]); rx = int'(ir[5:3]); ry = int'(ir[2:0]);
    k = step - 3;
    if (!exec || step == 7) begin
      e.clear = 1'b1;
      return e;
    end
    if (step == 0) begin
      src = 7; e.addrin = 1'b1; e.incr_pc = 1'b1;
    end else if (step == 2) begin
      src = 9; e.irin = 1'b1;
    end else if (step >= 3) begin
      case (op)
        0: if (k == 0) begin src = ry; dst = rx; e.done = 1'b1; end
        1: if (k == 0) begin src = 7; e.addrin = 1'b1; e.incr_pc = 1'b1; end
           else if (k == 2) begin src = 9; dst = rx; e.done = 1'b1; end
        2, 3: if (k == 0) begin src = rx; e.ain = 1'b1; end
              else if (k == 1) begin src = ry; e.gin = 1'b1; e.addsub = (op == 3); end
              else if (k == 2) begin src = 8; dst = rx; e.done = 1'b1; end
        4: if (k == 0) begin src = ry; e.addrin = 1'b1; end
           else if (k == 2) begin src = 9; dst = rx; e.done = 1'b1; end
        5: if (k == 0) begin src = ry; e.addrin = 1'b1; end
           else if (k == 1) begin src = rx; e.doutin = 1'b1; e.w_d = 1'b1; e.done = 1'b1; end
        6: if (k == 0) begin
             e.done = 1'b1;
             if (!MVNZ_EN) e.illegal = 1'b1;
             else if (!gz) begin src = ry; dst = rx; end
           end
        default: if (k == 0) begin e.done = 1'b1; e.illegal = 1'b1; end
      endcase
    end
    if (src >= 0 && src < 8) e.rout = 8'd1 << src;
    e.gout   = (src == 8);
    e.dinout = (src == 9);
    if (dst >= 0) e.rin = 8'd1 << dst;
    e.clear = e.done;
    return e;
  endfunction

  always_comb e_now = model_out(m_exec, m_step, m_ir, dp_if.G_zero);

  assign act = {Clear, Done, Illegal, dp_if.Rout, dp_if.Rin, dp_if.Gout, dp_if.DINout,
                dp_if.Ain, dp_if.Gin, dp_if.AddSub, dp_if.ADDRin, dp_if.DOUTin,
                dp_if.W_D, dp_if.incr_pc, dp_if.IRin};

  // Control FSM and step counter at the model level
  always @(posedge Clock) begin
    if (Reset) begin
      m_exec <= 1'b0; m_ir <= '0; m_step <= 0; Tstep <= 3'd0;
    end else begin
      if (m_exec && m_step == 2) m_ir <= dp_if.DIN;
      m_exec <= m_exec ? !(e_now.done && !Run) : Run;
      m_step <= e_now.clear ? 0 : m_step + 1;
      Tstep  <= e_now.clear ? 3'd0 : 3'(m_step + 1);
    end
  end

  always @(negedge Clock) begin
    if (cmp_en) begin
      checks++;
      if (act !== e_now) begin
        errors++;
        $display("FAIL outputs t=%0t step=%0d got %h want %h", $time, m_step, act, e_now);
      end
      checks++;
      if (dut.ir !== m_ir) begin
        errors++;
        $display("FAIL ir t=%0t got %h want %h", $time, dut.ir, m_ir);
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] w);
    checks++;
    if (a !== w) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, a, w);
    end
  endtask

  task automatic wait_step(input int s);
    int n;
    n = 0;
    do begin
      @(negedge Clock);
      n++;
    end while (!(m_exec && m_step == s) && n < 20);
    chk($sformatf("reach_T%0d", s), {31'd0, (m_exec && m_step == s)}, 32'd1);
  endtask

  task automatic next_instr(input logic [8:0] w, input logic gz);
    @(posedge Clock);
    #2;
    dp_if.DIN = w;
    dp_if.G_zero = gz;
  endtask

  task automatic measure(input string nm, input int want);
    int n;
    wait_step(0);
    n = 1;
    while (Done !== 1'b1 && n < 12) begin
      @(negedge Clock);
      n++;
    end
    chk(nm, n, want);
  endtask

  initial begin
    dp_if.DIN = '0;
    dp_if.G_zero = 1'b0;
    repeat (2) @(posedge Clock);
    #2;
    Reset = 1'b0;
    cmp_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge Clock);
      chk("idle_clear", Clear, 1);
      chk("idle_rout", dp_if.Rout, 0);
      chk("idle_ir", dut.ir, 0);
    end

    // mv R1,R2
    @(posedge Clock);
    #2;
    Run = 1'b1;
    dp_if.DIN = 9'b000_001_010;
    wait_step(3);
    chk("mv_rout", dp_if.Rout, 8'h04);
    chk("mv_rin", dp_if.Rin, 8'h02);
    chk("mv_done", Done, 1);
    chk("mv_clear", Clear, 1);
    chk("model_mv_rin", e_now.rin, 8'h02);

    // add R3,R4
    next_instr(9'b010_011_100, 1'b0);
    @(negedge Clock);
    chk("refetch_incr_pc", dp_if.incr_pc, 1);
    chk("refetch_rout", dp_if.Rout, 8'h80);
    wait_step(3);
    chk("add_t3_ain", dp_if.Ain, 1);
    chk("add_t3_rout", dp_if.Rout, 8'h08);
    wait_step(4);
    chk("add_t4_gin", dp_if.Gin, 1);
    chk("add_t4_addsub", dp_if.AddSub, 0);
    chk("add_t4_rout", dp_if.Rout, 8'h10);
    wait_step(5);
    chk("add_t5_gout", dp_if.Gout, 1);
    chk("add_t5_rin", dp_if.Rin, 8'h08);
    chk("add_t5_done", Done, 1);

    // sub R3,R4
    next_instr(9'b011_011_100, 1'b0);
    wait_step(4);
    chk("sub_t4_addsub", dp_if.AddSub, 1);
    chk("model_sub_addsub", e_now.addsub, 1);
    wait_step(5);

    // st R2,[R5]
    next_instr(9'b101_010_101, 1'b0);
    wait_step(3);
    chk("st_t3_rout", dp_if.Rout, 8'h20);
    chk("st_t3_addrin", dp_if.ADDRin, 1);
    wait_step(4);
    chk("st_t4_rout", dp_if.Rout, 8'h04);
    chk("st_t4_doutin", dp_if.DOUTin, 1);
    chk("st_t4_wd", dp_if.W_D, 1);
    chk("st_t4_done", Done, 1);

    // mvi R6
    next_instr(9'b001_110_000, 1'b0);
    measure("mvi_latency", 6);
    chk("mvi_rin", dp_if.Rin, 8'h40);
    chk("mvi_dinout", dp_if.DINout, 1);

    // opcode 110, G_zero=1 then 0
    next_instr(9'b110_001_010, 1'b1);
    wait_step(3);
    chk("mvnz_gz1_done", Done, 1);
    chk("mvnz_gz1_rin", dp_if.Rin, 0);
    chk("mvnz_gz1_illegal", Illegal, MVNZ_EN ? 32'd0 : 32'd1);
    next_instr(9'b110_001_010, 1'b0);
    wait_step(3);
    chk("mvnz_gz0_rin", dp_if.Rin, MVNZ_EN ? 32'h02 : 32'h00);
    chk("mvnz_gz0_illegal", Illegal, MVNZ_EN ? 32'd0 : 32'd1);

    // reserved
    next_instr(9'b111_000_000, 1'b0);
    measure("rsv_latency", 4);
    chk("rsv_illegal", Illegal, 1);
    chk("rsv_rin", dp_if.Rin, 0);

    // ld R4,[R1] aborted by Reset at T4
    next_instr(9'b100_100_001, 1'b0);
    wait_step(3);
    @(posedge Clock);
    #2;
    Reset = 1'b1;
    @(posedge Clock);
    #2;
    Reset = 1'b0;
    dp_if.DIN = 9'b001_101_000;
    @(negedge Clock);
    chk("rst_rin", dp_if.Rin, 0);
    chk("rst_wd", dp_if.W_D, 0);
    chk("rst_incr_pc", dp_if.incr_pc, 0);
    chk("rst_clear", Clear, 1);

    // mvi R5 with Run dropped at T1
    wait_step(0);
    @(posedge Clock);
    #2;
    Run = 1'b0;
    wait_step(5);
    chk("mvi2_done", Done, 1);
    chk("mvi2_rin", dp_if.Rin, 8'h20);
    @(negedge Clock);
    chk("post_clear", Clear, 1);
    chk("post_rout", dp_if.Rout, 0);
    chk("model_idle", {31'd0, m_exec}, 0);
    repeat (3) @(negedge Clock);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/unidade_controle.md
# unidade_controle

Instruction-sequencing control unit for the 9-bit-instruction multicycle processor. Consumes the 3-bit step count `Tstep` from the step counter and drives that counter's `Clear`. It holds the instruction register and decodes opcode × step into one-hot register-file, ALU, memory and PC strobes. Sits between the step counter and the datapath (register file R0–R7, A/G registers, ADDR/DOUT registers, bus mux).

## Interface
- `N`, default 9: instruction width; opcode `IR[8:6]`, Rx `IR[5:3]`, Ry `IR[2:0]`.
- `Clock`  in  1  system clock; all state updates on rising edge.
- `Reset`  in  1  reset, synchronous, active-high.
- `Run`  in  1  level; start or continue instruction execution.
- `Tstep`  in  3  current step from the step counter.
- `DIN`  in  N  memory read data; source for IR load.
- `G_zero`  in  1  G register equals zero.
- `Clear`  out  1  step-counter clear.
- `Done`  out  1  last step of the current instruction.
- `Illegal`  out  1  one-cycle pulse on reserved opcode.
- `Rout`, `Rin`  out  8  one-hot register bus-drive / load selects.
- `Gout`, `DINout`, `Ain`, `Gin`, `AddSub`, `ADDRin`, `DOUTin`, `W_D`, `incr_pc`, `IRin`  out  1  datapath strobes.

## Operation
- FSM states: IDLE, EXEC (1 flop). IR register (N flops).
- IDLE: `Clear`=1, all strobes 0. `Run`=1 → EXEC next edge, so `Tstep`=0 on entry.
- Fetch, all opcodes:
  - T0: `Rout[7]`, `ADDRin`, `incr_pc`.
  - T1: memory wait, no strobes.
  - T2: `DINout`, `IRin`; IR ← DIN.
- Execute, decoded from IR:
  - 000 mv: T3 `Rout[Ry]`, `Rin[Rx]`, Done.
  - 001 mvi: T3 `Rout[7]`, `ADDRin`, `incr_pc`; T4 wait; T5 `DINout`, `Rin[Rx]`, Done.
  - 010 add / 011 sub: T3 `Rout[Rx]`, `Ain`; T4 `Rout[Ry]`, `Gin`, `AddSub`=opcode[0]; T5 `Gout`, `Rin[Rx]`, Done.
  - 100 ld: T3 `Rout[Ry]`, `ADDRin`; T4 wait; T5 `DINout`, `Rin[Rx]`, Done.
  - 101 st: T3 `Rout[Ry]`, `ADDRin`; T4 `Rout[Rx]`, `DOUTin`, `W_D`, Done.
  - 110 mvnz: see Configuration.
  - 111 reserved: T3 Done, `Illegal`, no writes.
- `Clear` = Done OR IDLE OR (`Tstep`==7 in EXEC; safety recovery, no strobes).
- On Done: `Run`=1 → stay EXEC, next instruction begins at T0; `Run`=0 → IDLE.
- `Rout`, `Rin` always one-hot or zero; at most one bus driver per cycle.

## Timing
- Strobes, Done, Clear, Illegal: combinational from state, `Tstep`, IR; registered consumers act on the next edge.
- Reset values: state IDLE, IR=0, `Clear`=1, every other output 0.
- Instruction latency from first T0: mv / reserved 4 cycles; st 5; mvi / add / sub / ld 6.
- Reset mid-instruction: abort. No `Rin`/`W_D`/`incr_pc` in the cycle after Reset is sampled.
- `Run` falling mid-instruction: current instruction completes; IDLE after Done.
- `Run`=1 during Reset: ignored; EXEC entered on the first edge after Reset=0.
- IR changes only on T2 of EXEC.

## Configuration
- `CTRL_MVNZ_EN` defined: opcode 110 = mvnz. T3: if `G_zero`=0 then `Rout[Ry]` and `Rin[Rx]`; Done asserted either way.
- Undefined: opcode 110 treated as reserved: T3 Done, `Illegal`, no writes.

## Structure
- Shared package `proc_defs`:
  - opcode constants `OP_MV`…`OP_RSV`
  - step constants `T0`…`T7`
  - state encoding `ST_IDLE`/`ST_EXEC`
  - `PC_IDX`=7
- Sub-module `dec3to8`: 3-bit index to one-hot 8 with enable. Instantiated for `Rout` and `Rin` selects.
- The step counter stays a separate instance at the processor level.

## Test plan
- Reset held 2 cycles, `Run`=0 → `Clear`=1, all strobes 0, IR=0; hold 5 cycles unchanged.
- `Run`=1, DIN=9'b000_001_010 at T2 (mv R1,R2) → T3 `Rout`=8'h04, `Rin`=8'h02, Done=1, Clear=1; `Run` still 1 → T0 fetch next cycle.
- add R3,R4 (9'b010_011_100) → T3 `Ain` with `Rout`=8'h08; T4 `Gin`, `AddSub`=0, `Rout`=8'h10; T5 `Gout`, `Rin`=8'h08, Done; sub variant shows `AddSub`=1 at T4.
- st R2,[R5] → T3 `Rout`=8'h20, `ADDRin`; T4 `Rout`=8'h04, `DOUTin`, `W_D`=1, Done.
- Opcode 110 with `G_zero`=1 then `G_zero`=0, built with and without `CTRL_MVNZ_EN`:
  - with, `G_zero`=1: Done, `Rin`=0.
  - with, `G_zero`=0: `Rin[Rx]`=1.
  - without: `Illegal`=1, `Rin`=0.
- Reset asserted at T4 of ld, `Run` dropped at T1 of mvi → no writes after Reset; mvi completes at T5 then IDLE, `Clear`=1.
